// File: rtl/sdes_pkg.sv
// sdes_pkg: shared definitions for the sequential S-DES controller.
//   - FSM state encodings (IDLE, R1, R2, DONE)
//   - S-DES permutation, expansion, S-box and key-schedule helpers
// Bit numbering: bit [N-1] of every vector is bit 1 of the standard.
// Optional feature macro used by the controller: SDES_CTRL_DECRYPT_EN.
package sdes_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] R1   = 2'd1;
  localparam logic [1:0] R2   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  function automatic logic [7:0] ip(input logic [7:0] x);
    return {x[6], x[2], x[5], x[7], x[4], x[0], x[3], x[1]};
  endfunction

  function automatic logic [7:0] iip(input logic [7:0] x);
    return {x[4], x[7], x[5], x[3], x[1], x[6], x[0], x[2]};
  endfunction

  function automatic logic [7:0] ep(input logic [3:0] r);
    return {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]};
  endfunction

  function automatic logic [3:0] p4(input logic [3:0] s);
    return {s[2], s[0], s[1], s[3]};
  endfunction

  // Row = outer bits {3,0}, column = inner bits {2,1}; index = row*4 + col.
  function automatic logic [1:0] s0(input logic [3:0] n);
    logic [1:0] v;
    case ({n[3], n[0], n[2], n[1]})
      4'd0:    v = 2'd1;
      4'd1:    v = 2'd0;
      4'd2:    v = 2'd3;
      4'd3:    v = 2'd2;
      4'd4:    v = 2'd3;
      4'd5:    v = 2'd2;
      4'd6:    v = 2'd1;
      4'd7:    v = 2'd0;
      4'd8:    v = 2'd0;
      4'd9:    v = 2'd2;
      4'd10:   v = 2'd1;
      4'd11:   v = 2'd3;
      4'd12:   v = 2'd3;
      4'd13:   v = 2'd1;
      4'd14:   v = 2'd3;
      default: v = 2'd2;
    endcase
    return v;
  endfunction

  function automatic logic [1:0] s1(input logic [3:0] n);
    logic [1:0] v;
    case ({n[3], n[0], n[2], n[1]})
      4'd0:    v = 2'd0;
      4'd1:    v = 2'd1;
      4'd2:    v = 2'd2;
      4'd3:    v = 2'd3;
      4'd4:    v = 2'd2;
      4'd5:    v = 2'd0;
      4'd6:    v = 2'd1;
      4'd7:    v = 2'd3;
      4'd8:    v = 2'd3;
      4'd9:    v = 2'd0;
      4'd10:   v = 2'd1;
      4'd11:   v = 2'd0;
      4'd12:   v = 2'd2;
      4'd13:   v = 2'd1;
      4'd14:   v = 2'd0;
      default: v = 2'd3;
    endcase
    return v;
  endfunction

  // P10, shifts and P8 flattened into direct bit selects.
  function automatic logic [7:0] k1_of(input logic [9:0] key);
    return {key[9], key[3], key[1], key[6], key[2], key[7], key[0], key[4]};
  endfunction

  function automatic logic [7:0] k2_of(input logic [9:0] key);
    return {key[2], key[7], key[4], key[5], key[0], key[8], key[1], key[9]};
  endfunction

endpackage

// File: rtl/sdes_ctrl_round.sv
// sdes_round: one combinational S-DES Feistel round, without the swap.
//   l_in  [3:0]  left half
//   r_in  [3:0]  right half
//   key   [7:0]  round key
//   l_out [3:0]  l_in ^ F(r_in, key)
module sdes_round
  import sdes_pkg::*;
(
  input  logic [3:0] l_in,
  input  logic [3:0] r_in,
  input  logic [7:0] key,
  output logic [3:0] l_out
);

  logic [7:0] mixed;
  logic [3:0] sbox_out;

  always_comb begin
    mixed    = ep(r_in) ^ key;
    sbox_out = {s0(mixed[7:4]), s1(mixed[3:0])};
    l_out    = l_in ^ p4(sbox_out);
  end

endmodule

// File: rtl/sdes_ctrl.sv
// sdes_ctrl: sequential S-DES engine. One block + key accepted over a
// valid/ready handshake, two rounds on a shared round instance (one per
// clock), result returned over a second valid/ready handshake.
//   clk, rst             clock, async active-high reset
//   in_valid/in_ready    input handshake; in_data[7:0], in_key[9:0]
//   decrypt              only with SDES_CTRL_DECRYPT_EN: swap key order
//   out_valid/out_ready  output handshake; out_data[7:0]
//   busy                 high whenever the FSM is not IDLE
// Macro SDES_CTRL_DECRYPT_EN adds the decrypt port and mode register;
// without it the block always encrypts.
module sdes_ctrl
  import sdes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [9:0] in_key,
`ifdef SDES_CTRL_DECRYPT_EN
  input  logic       decrypt,
`endif
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
);

  logic [1:0] state_q, state_d;
  logic [3:0] l_q, l_d;
  logic [3:0] r_q, r_d;
  logic [7:0] k1_q, k1_d;
  logic [7:0] k2_q, k2_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
`ifdef SDES_CTRL_DECRYPT_EN
  logic       dec_q, dec_d;
`endif

  logic       accept;
  logic       use_k1;
  logic [7:0] round_key;
  logic [3:0] round_l;

  assign in_ready  = (state_q == IDLE) & ~rst;
  assign accept    = in_valid & in_ready;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // First round uses k1 and second k2; decrypt mode inverts that choice.
`ifdef SDES_CTRL_DECRYPT_EN
  assign use_k1 = (state_q == R1) ^ dec_q;
`else
  assign use_k1 = (state_q == R1);
`endif
  assign round_key = use_k1 ? k1_q : k2_q;

  sdes_round u_round (
    .l_in  (l_q),
    .r_in  (r_q),
    .key   (round_key),
    .l_out (round_l)
  );

  always_comb begin
    state_d     = state_q;
    l_d         = l_q;
    r_d         = r_q;
    k1_d        = k1_q;
    k2_d        = k2_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
`ifdef SDES_CTRL_DECRYPT_EN
    dec_d       = dec_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          {l_d, r_d} = ip(in_data);
          k1_d       = k1_of(in_key);
          k2_d       = k2_of(in_key);
`ifdef SDES_CTRL_DECRYPT_EN
          dec_d      = decrypt;
`endif
          state_d    = R1;
        end
      end
      R1: begin
        // Round plus the inter-round swap in a single update.
        l_d     = r_q;
        r_d     = round_l;
        state_d = R2;
      end
      R2: begin
        out_data_d  = iip({round_l, r_q});
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      l_q         <= 4'h0;
      r_q         <= 4'h0;
      k1_q        <= 8'h00;
      k2_q        <= 8'h00;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
`ifdef SDES_CTRL_DECRYPT_EN
      dec_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      l_q         <= l_d;
      r_q         <= r_d;
      k1_q        <= k1_d;
      k2_q        <= k2_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
`ifdef SDES_CTRL_DECRYPT_EN
      dec_q       <= dec_d;
`endif
    end
  end

endmodule
